// File: rtl/alu_pipe.sv
// Two-stage pipelined 8-op ALU with C/V/Z/N flags and a handshake counter; latency 2 clocks, 1 beat/cycle.
// Back-pressure: a stalled output holds S2 and, when S1 is occupied, drops in_ready combinationally.
module alu_pipe #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in1_val,
  input  logic [N-1:0]     in2_val,
  input  logic [2:0]       mux_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out1_val,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_NOT  = 3'b001,
    OP_ADD  = 3'b010,
    OP_NOR  = 3'b011,
    OP_SUB  = 3'b100,
    OP_NAND = 3'b101,
    OP_AND  = 3'b110,
    OP_SLT  = 3'b111
  } op_e;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    op_e          op;
    logic         cin;
  } s1_t;

  typedef struct packed {
    logic [N-1:0] r;
    logic         c;
    logic         v;
  } res_t;

  logic s1_valid;
  logic s2_valid;
  s1_t  s1_q;
  res_t res;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [N:0] sum_ext;
  logic [N:0] diff_ext;
  logic       slt_bit;

  // SUB is A + ~B + 1 so the carry reads as "no borrow".
  assign sum_ext  = {1'b0, s1_q.a} + {1'b0, s1_q.b} + (N+1)'(s1_q.cin);
  assign diff_ext = {1'b0, s1_q.a} + {1'b0, ~s1_q.b} + (N+1)'(1);
  // A true signed compare stays correct where A-B overflows.
  assign slt_bit  = $signed(s1_q.a) < $signed(s1_q.b);

  always_comb begin
    res = '0;
    unique case (s1_q.op)
      OP_MOV:  res.r = s1_q.a;
      OP_NOT:  res.r = ~s1_q.a;
      OP_ADD: begin
        res.r = sum_ext[N-1:0];
        res.c = sum_ext[N];
        res.v = (s1_q.a[N-1] == s1_q.b[N-1]) && (sum_ext[N-1] != s1_q.a[N-1]);
      end
      OP_NOR:  res.r = ~(s1_q.a | s1_q.b);
      OP_SUB: begin
        res.r = diff_ext[N-1:0];
        res.c = diff_ext[N];
        res.v = (s1_q.a[N-1] != s1_q.b[N-1]) && (diff_ext[N-1] != s1_q.a[N-1]);
      end
      OP_NAND: res.r = ~(s1_q.a & s1_q.b);
      OP_AND:  res.r = s1_q.a & s1_q.b;
      OP_SLT:  res.r = {{(N-1){1'b0}}, slt_bit};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.a   <= in1_val;
        s1_q.b   <= in2_val;
        s1_q.op  <= op_e'(mux_in);
        s1_q.cin <= c_in;
      end
    end
  end

  // Output data is only refreshed by a real beat; bubbles leave it stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out1_val <= '0;
      c_out    <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out1_val <= res.r;
        c_out    <= res.c;
        ovf      <= res.v;
        zero     <= (res.r == '0);
        neg      <= res.r[N-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (s2_valid && out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule
